// File: rtl/pong_score_scheduler.sv
// Pong scoreboard: BCD scores committed in vertical blank, play/game-over FSM,
// and a per-pixel time-shared digit slot scheduler feeding one seven-segment renderer.
//
// state     | meaning
// PLAY      | points collected as pending flags, committed at frame_start
// GAME_OVER | scores frozen, winner's digits blink every BLINK_FRAMES frames
module pong_score_scheduler #(
  parameter int         WIN_SCORE    = 11,
  parameter logic [9:0] LEFT_X       = 10'd260,
  parameter logic [9:0] RIGHT_X      = 10'd340,
  parameter logic [9:0] DIGIT_Y      = 10'd16,
  parameter logic [9:0] DIGIT_PITCH  = 10'd24,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  input  logic       frame_start,
  input  logic       point_left,
  input  logic       point_right,
  input  logic       new_game,
  output logic [9:0] digit_x,
  output logic [9:0] digit_y,
  output logic [3:0] digit,
  output logic [9:0] xpos_q,
  output logic [9:0] ypos_q,
  output logic [7:0] score_left,
  output logic [7:0] score_right,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic {
    PLAY      = 1'b0,
    GAME_OVER = 1'b1
  } stateT;

  localparam int         BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [7:0] WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [9:0] LO_X       = LEFT_X + DIGIT_PITCH;
  localparam logic [9:0] RO_X       = RIGHT_X + DIGIT_PITCH;
  localparam logic [3:0] BLANK      = 4'hF;

  stateT         state, stateNext;
  logic [7:0]    scoreL, scoreLNext, scoreR, scoreRNext;
  logic [7:0]    incL, incR;
  logic          pendL, pendLNext, pendR, pendRNext;
  logic [BW-1:0] blinkCnt, blinkCntNext;
  logic          blinkOff, blinkOffNext;
  logic          winnerQ, winnerNext;
  logic          hitL, hitR;

  function automatic logic [7:0] bcdInc(input logic [7:0] s);
    if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  // Widened to 11 bits so slots near the right edge cannot wrap
  function automatic logic inSlot(input logic [9:0] x, input logic [9:0] sx);
    logic [10:0] lo;
    logic [10:0] hi;
    lo = {1'b0, sx};
    hi = {1'b0, sx} + {1'b0, DIGIT_PITCH} - 11'd1;
    return ({1'b0, x} >= lo) && ({1'b0, x} <= hi);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PLAY;
      scoreL   <= 8'h00;
      scoreR   <= 8'h00;
      pendL    <= 1'b0;
      pendR    <= 1'b0;
      blinkCnt <= '0;
      blinkOff <= 1'b0;
      winnerQ  <= 1'b0;
    end else begin
      state    <= stateNext;
      scoreL   <= scoreLNext;
      scoreR   <= scoreRNext;
      pendL    <= pendLNext;
      pendR    <= pendRNext;
      blinkCnt <= blinkCntNext;
      blinkOff <= blinkOffNext;
      winnerQ  <= winnerNext;
    end
  end

  always_comb begin
    stateNext    = state;
    scoreLNext   = scoreL;
    scoreRNext   = scoreR;
    pendLNext    = pendL;
    pendRNext    = pendR;
    blinkCntNext = blinkCnt;
    blinkOffNext = blinkOff;
    winnerNext   = winnerQ;
    hitL         = pendL | point_left;
    hitR         = pendR | point_right;
    incL         = bcdInc(scoreL);
    incR         = bcdInc(scoreR);

    if (new_game) begin
      stateNext    = PLAY;
      scoreLNext   = 8'h00;
      scoreRNext   = 8'h00;
      pendLNext    = 1'b0;
      pendRNext    = 1'b0;
      blinkCntNext = '0;
      blinkOffNext = 1'b0;
      winnerNext   = 1'b0;
    end else if (state == PLAY) begin
      pendLNext    = hitL;
      pendRNext    = hitR;
      blinkCntNext = '0;
      blinkOffNext = 1'b0;
      if (frame_start) begin
        pendLNext = 1'b0;
        pendRNext = 1'b0;
        if (hitL) scoreLNext = incL;
        // A left win discards the right player's point from the same frame
        if (hitL && incL == WIN_BCD) begin
          stateNext  = GAME_OVER;
          winnerNext = 1'b0;
        end else if (hitR) begin
          scoreRNext = incR;
          if (incR == WIN_BCD) begin
            stateNext  = GAME_OVER;
            winnerNext = 1'b1;
          end
        end
      end
    end else begin
      pendLNext = 1'b0;
      pendRNext = 1'b0;
      if (frame_start) begin
        if (blinkCnt == BLINK_LAST) begin
          blinkCntNext = '0;
          blinkOffNext = ~blinkOff;
        end else begin
          blinkCntNext = blinkCnt + BW'(1);
        end
      end
    end
  end

  logic       yHit;
  logic       blankL, blankR;
  logic [3:0] ltVal, loVal, rtVal, roVal;
  logic [3:0] digitD;
  logic [9:0] digitXD, digitYD;

  assign yHit = ({1'b0, ypos} >= {1'b0, DIGIT_Y}) &&
                ({1'b0, ypos} <= ({1'b0, DIGIT_Y} + 11'd31));

  always_comb begin
    blankL = (state == GAME_OVER) && blinkOff && !winnerQ;
    blankR = (state == GAME_OVER) && blinkOff && winnerQ;
    ltVal  = (blankL || scoreL[7:4] == 4'd0) ? BLANK : scoreL[7:4];
    loVal  = blankL ? BLANK : scoreL[3:0];
    rtVal  = (blankR || scoreR[7:4] == 4'd0) ? BLANK : scoreR[7:4];
    roVal  = blankR ? BLANK : scoreR[3:0];

    digitD  = BLANK;
    digitXD = 10'd0;
    digitYD = 10'd0;
    if (yHit) begin
      if (inSlot(xpos, LEFT_X)) begin
        digitD  = ltVal;
        digitXD = LEFT_X;
        digitYD = DIGIT_Y;
      end else if (inSlot(xpos, LO_X)) begin
        digitD  = loVal;
        digitXD = LO_X;
        digitYD = DIGIT_Y;
      end else if (inSlot(xpos, RIGHT_X)) begin
        digitD  = rtVal;
        digitXD = RIGHT_X;
        digitYD = DIGIT_Y;
      end else if (inSlot(xpos, RO_X)) begin
        digitD  = roVal;
        digitXD = RO_X;
        digitYD = DIGIT_Y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit   <= BLANK;
      digit_x <= 10'd0;
      digit_y <= 10'd0;
      xpos_q  <= 10'd0;
      ypos_q  <= 10'd0;
    end else begin
      digit   <= digitD;
      digit_x <= digitXD;
      digit_y <= digitYD;
      xpos_q  <= xpos;
      ypos_q  <= ypos;
    end
  end

  assign score_left  = scoreL;
  assign score_right = scoreR;
  assign game_over   = (state == GAME_OVER);
  assign winner      = winnerQ;

endmodule

// File: tb/tb_pong_score_scheduler.sv
// Self-checking bench for pong_score_scheduler: scoring, drop/commit timing,
// win/blink behaviour and the slot scheduler via a pixel scoreboard queue.
module tb_pong_score_scheduler;

  localparam int LX = 260;
  localparam int RX = 340;
  localparam int DY = 16;
  localparam int P  = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] xpos = '0, ypos = '0;
  logic       frame_start = 1'b0, point_left = 1'b0, point_right = 1'b0, new_game = 1'b0;
  logic [9:0] digit_x, digit_y, xpos_q, ypos_q;
  logic [3:0] digit;
  logic [7:0] score_left, score_right;
  logic       game_over, winner;

  int testCount = 0;
  int failCount = 0;

  logic [7:0] mScoreL = 8'h00, mScoreR = 8'h00;
  logic       mOver = 1'b0, mWinner = 1'b0, mBlinkOff = 1'b0;

  logic [43:0] expQ[$];

  pong_score_scheduler #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .xpos(xpos), .ypos(ypos),
    .frame_start(frame_start), .point_left(point_left), .point_right(point_right),
    .new_game(new_game), .digit_x(digit_x), .digit_y(digit_y), .digit(digit),
    .xpos_q(xpos_q), .ypos_q(ypos_q), .score_left(score_left), .score_right(score_right),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcdInc(input logic [7:0] s);
    if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [23:0] expPix(input int x, input int y);
    logic [3:0] lt, lo, rt, ro;
    lt = (mScoreL[7:4] == 4'd0) ? 4'hF : mScoreL[7:4];
    lo = mScoreL[3:0];
    rt = (mScoreR[7:4] == 4'd0) ? 4'hF : mScoreR[7:4];
    ro = mScoreR[3:0];
    if (mOver && mBlinkOff && !mWinner) begin lt = 4'hF; lo = 4'hF; end
    if (mOver && mBlinkOff && mWinner)  begin rt = 4'hF; ro = 4'hF; end
    if (y < DY || y > DY + 31) return {20'd0, 4'hF};
    if (x >= LX && x < LX + P)         return {10'(LX), 10'(DY), lt};
    if (x >= LX + P && x < LX + 2 * P) return {10'(LX + P), 10'(DY), lo};
    if (x >= RX && x < RX + P)         return {10'(RX), 10'(DY), rt};
    if (x >= RX + P && x < RX + 2 * P) return {10'(RX + P), 10'(DY), ro};
    return {20'd0, 4'hF};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doCycle(input logic fs, input logic pl, input logic pr, input logic ng);
    frame_start = fs; point_left = pl; point_right = pr; new_game = ng;
    tick();
    frame_start = 1'b0; point_left = 1'b0; point_right = 1'b0; new_game = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    logic [43:0] got, want;
    xpos = 10'(x); ypos = 10'(y);
    expQ.push_back({10'(x), 10'(y), expPix(x, y)});
    tick();
    got  = {xpos_q, ypos_q, digit_x, digit_y, digit};
    want = expQ.pop_front();
    testCount++;
    if (got !== want) begin
      failCount++;
      $display("FAIL pixel(%0d,%0d): got xq/yq/dx/dy/d=%h required %h", x, y, got, want);
    end
  endtask

  task automatic probeRow(input int y);
    int sx[4];
    sx = '{LX, LX + P, RX, RX + P};
    for (int i = 0; i < 4; i++) begin
      probe(sx[i] - 1, y);
      probe(sx[i], y);
      probe(sx[i] + P - 1, y);
    end
    probe(RX + 2 * P, y);
  endtask

  task automatic checkScores(input string tag);
    testCount++;
    if (score_left !== mScoreL || score_right !== mScoreR || game_over !== mOver ||
        (mOver && winner !== mWinner)) begin
      failCount++;
      $display("FAIL %s: got L=%h R=%h over=%b win=%b required L=%h R=%h over=%b win=%b",
               tag, score_left, score_right, game_over, winner, mScoreL, mScoreR, mOver, mWinner);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); reset = 1'b0;
    doCycle(1'b1, 1'b1, 1'b1, 1'b0);
    reset = 1'b1; point_left = 1'b1; new_game = 1'b1; frame_start = 1'b1;
    tick();
    testCount++;
    if (score_left !== 8'h00 || score_right !== 8'h00 || game_over !== 1'b0 || winner !== 1'b0 ||
        digit !== 4'hF || digit_x !== 10'd0 || digit_y !== 10'd0) begin
      failCount++;
      $display("FAIL reset: got L=%h R=%h over=%b win=%b d=%h dx=%0d dy=%0d required 00 00 0 0 f 0 0",
               score_left, score_right, game_over, winner, digit, digit_x, digit_y);
    end
    reset = 1'b0; point_left = 1'b0; new_game = 1'b0; frame_start = 1'b0;
    mScoreL = 8'h00; mScoreR = 8'h00; mOver = 1'b0; mBlinkOff = 1'b0;
    probeRow(DY);
    probeRow(DY + 31);
    probe(LX + 30, DY - 1);
    probe(LX + 30, DY + 32);
  endtask

  task automatic test_bcd_carry();
    for (int i = 0; i < 10; i++) begin
      doCycle(1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 0) checkScores("no_commit_before_frame");
      doCycle(1'b1, 1'b0, 1'b0, 1'b0);
      mScoreL = bcdInc(mScoreL);
      checkScores("left_point");
    end
    testCount++;
    if (score_left !== 8'h10) begin
      failCount++;
      $display("FAIL bcd_carry: got %h required 10", score_left);
    end
    probe(LX + 2, DY + 2);
    probeRow(DY + 2);
  endtask

  task automatic test_drop_and_same_cycle();
    doCycle(1'b0, 1'b0, 1'b1, 1'b0);
    doCycle(1'b0, 1'b0, 1'b1, 1'b0);
    doCycle(1'b0, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 1'b0, 1'b1, 1'b0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    mScoreR = 8'h01;
    checkScores("drop_extra_pulses");
    doCycle(1'b1, 1'b0, 1'b1, 1'b0);
    mScoreR = 8'h02;
    checkScores("same_cycle_commit");
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 1'b0, 1'b1, 1'b0);
    checkScores("late_pulse_waits");
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    mScoreR = 8'h03;
    checkScores("late_pulse_next_frame");
    probeRow(DY + 10);
  endtask

  task automatic test_simultaneous_win();
    for (int i = 0; i < 7; i++) begin
      doCycle(1'b0, 1'b0, 1'b1, 1'b0);
      doCycle(1'b1, 1'b0, 1'b0, 1'b0);
      mScoreR = bcdInc(mScoreR);
    end
    checkScores("ten_ten");
    doCycle(1'b0, 1'b1, 1'b1, 1'b0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    mScoreL = 8'h11; mScoreR = 8'h10; mOver = 1'b1; mWinner = 1'b0; mBlinkOff = 1'b0;
    checkScores("left_wins_right_dropped");
    doCycle(1'b0, 1'b1, 1'b1, 1'b0);
    checkScores("points_ignored");
    probeRow(DY + 4);
  endtask

  task automatic test_blink();
    doCycle(1'b1, 1'b1, 1'b1, 1'b0);
    checkScores("frame_points_ignored");
    probeRow(DY + 5);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    mBlinkOff = 1'b1;
    probeRow(DY + 5);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    probeRow(DY + 6);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    mBlinkOff = 1'b0;
    probeRow(DY + 7);
    checkScores("blink_scores_steady");
  endtask

  task automatic test_new_game();
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    mBlinkOff = 1'b1;
    probeRow(DY + 8);
    doCycle(1'b1, 1'b1, 1'b0, 1'b1);
    mScoreL = 8'h00; mScoreR = 8'h00; mOver = 1'b0; mBlinkOff = 1'b0;
    checkScores("new_game_override");
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkScores("new_game_point_discarded");
    probeRow(DY + 9);
  endtask

  task automatic test_right_win();
    for (int i = 0; i < 11; i++) begin
      doCycle(1'b0, 1'b0, 1'b1, 1'b0);
      doCycle(1'b1, 1'b0, 1'b0, 1'b0);
      mScoreR = bcdInc(mScoreR);
      if (i == 9) checkScores("right_at_ten");
    end
    mOver = 1'b1; mWinner = 1'b1; mBlinkOff = 1'b0;
    checkScores("right_wins");
    probeRow(DY + 20);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    mBlinkOff = 1'b1;
    probeRow(DY + 21);
  endtask

  initial begin
    test_reset();
    test_bcd_carry();
    test_drop_and_same_cycle();
    test_simultaneous_win();
    test_blink();
    test_new_game();
    test_right_win();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/pong_score_scheduler.md
# pong_score_scheduler

Scoreboard controller for the Pong VGA path. Holds both players' scores as two-digit BCD counters, commits point events only during vertical blank, and runs the play/game-over state machine. Every pixel clock it time-shares a single combinational seven-segment digit renderer across four on-screen digit slots by driving the renderer's digit position, digit value and pixel coordinates. The renderer's pixel flag is OR'd into the video mux downstream.

## Interface
Parameters:
- `WIN_SCORE`, default 11: points needed to win; legal range 1..99.
- `LEFT_X`, default 10'd260: x of the left player's tens digit slot.
- `RIGHT_X`, default 10'd340: x of the right player's tens digit slot.
- `DIGIT_Y`, default 10'd16: y of all digit slots.
- `DIGIT_PITCH`, default 10'd24: slot width; the ones slot sits at tens x + `DIGIT_PITCH`.
- `BLINK_FRAMES`, default 30: frames per on/off half-period of the winner blink.

Ports:
- `clk`  in  1: pixel clock.
- `reset`  in  1: synchronous, active-high.
- `xpos`, `ypos`  in  10 each: current pixel coordinate from the sync generator.
- `frame_start`  in  1: one-cycle pulse at start of vertical blank.
- `point_left`, `point_right`  in  1 each: one-cycle score pulses from game logic.
- `new_game`  in  1: one-cycle pulse that restarts the match.
- `digit_x`, `digit_y`  out  10 each: registered slot origin for the renderer.
- `digit`  out  4: registered digit value. 4'hF means blank; the renderer outputs 0 for it.
- `xpos_q`, `ypos_q`  out  10 each: `xpos`/`ypos` delayed one cycle, aligned with `digit*`.
- `score_left`, `score_right`  out  8 each: committed BCD score, {tens, ones}.
- `game_over`  out  1: high in state GAME_OVER.
- `winner`  out  1: 0 = left, 1 = right. Valid while `game_over` is high.

## Operation
- **Reset.** All outputs are 0, except `digit` = 4'hF. Pending flags and blink counter are cleared. State = PLAY.
- **Pending flags.**
  - `point_left`/`point_right` in PLAY set a sticky pending flag per player.
  - Further pulses before the next `frame_start` are dropped, so at most 1 point per player per frame.
  - Pulses in GAME_OVER are ignored.
- **Commit at `frame_start` in PLAY.**
  - Left pending is applied first. BCD increment: ones 9 -> 0 with tens+1.
  - If left reaches `WIN_SCORE`: go to GAME_OVER with `winner`=0, and discard the right pending point.
  - Otherwise apply right pending; if right reaches `WIN_SCORE`, go to GAME_OVER with `winner`=1.
  - Pending flags clear on every `frame_start`.
  - Scores never change outside a `frame_start` cycle, except on `new_game`/`reset`.
- **GAME_OVER.**
  - The blink counter counts `frame_start` pulses 0..`BLINK_FRAMES`-1 and wraps; `blink_off` toggles on each wrap.
  - The counter and `blink_off` are 0 on entry to GAME_OVER.
- **`new_game`.** In any state, on the same edge: scores = 00, pending cleared, blink cleared, state = PLAY.
  - It overrides a coincident `frame_start` or point pulse; those are discarded.
- **Slot scheduling.** Slots are LT at `LEFT_X`, LO at `LEFT_X`+`DIGIT_PITCH`, RT at `RIGHT_X`, RO at `RIGHT_X`+`DIGIT_PITCH`.
  - A pixel hits a slot when x is in [slot_x, slot_x+`DIGIT_PITCH`-1] and y is in [`DIGIT_Y`, `DIGIT_Y`+31].
  - On a hit, register `digit_x`=slot_x, `digit_y`=`DIGIT_Y`, and `digit` = that BCD nibble.
  - Tens nibble 0 is shown as 4'hF (leading-zero blanking). A ones digit of 0 is always shown.
  - In GAME_OVER with `blink_off`=1, both of the winner's slots are shown as 4'hF.
  - No hit: `digit`=4'hF, `digit_x`=`digit_y`=0.
  - Slots must not overlap. If they do, priority is LT > LO > RT > RO.

## Timing
- Slot lookup latency is exactly 1 cycle: `digit*`, `xpos_q` and `ypos_q` all reflect the previous cycle's `xpos`/`ypos`.
- Score commit: `score_*`, `game_over` and `winner` update on the `clk` edge that samples `frame_start`=1. They are visible the cycle after.
- A point pulse in the same cycle as `frame_start` is committed in that same frame.
- A point pulse one cycle after `frame_start` waits for the next frame.
- `reset` has priority over everything, including `new_game`.

## Test plan
- **Reset.** Assert `reset` 1 cycle. Expect score_left=score_right=8'h00, game_over=0, and digit=4'hF at all pixels, except LO/RO slots showing 0.
- **BCD carry and blanking.** Apply 10 left points, one per frame. Expect score_left=8'h10. At pixel (LEFT_X+2, DIGIT_Y+2), expect digit=1 and digit_x=LEFT_X one cycle later.
- **Drop and same-cycle commit.**
  - 3 `point_right` pulses in one frame: expect score_right to advance by exactly 1.
  - Pulse coincident with `frame_start`: expect it committed that edge.
- **Simultaneous win.** Scores 10-10, both pending at `frame_start`. Expect score_left=8'h11, score_right=8'h10, game_over=1, winner=0. Further points ignored.
- **Blink.** In GAME_OVER with BLINK_FRAMES=2, after 2 `frame_start`s expect the winner's slots to read 4'hF. After 2 more, expect the digits restored. The loser's digits are steady throughout.
- **`new_game` override.** `new_game` coincident with `frame_start` and `point_left` in GAME_OVER. Expect scores 00, game_over=0, blink cleared, point discarded.
